mac_accum_int4: RTL and testbench
=================================

Name: mac_accum_int4

Overview:
- Sequential accumulator stage directly downstream of the 4-bit integer multiplier (mul_int4 / multiplier_nbit).
- Consumes one WIDTH-bit product P per accepted beat over a valid/ready handshake.
- Sums LEN consecutive products into an ACC_WIDTH-bit dot-product result, with a sticky overflow flag.
- Presents the result on a registered valid/ready output port; together with the multiplier this forms a multiply-accumulate lane.

Parameters:
- WIDTH, 4, product width; matches the multiplier's P width.
- ACC_WIDTH, 12, accumulator/result width; must be >= WIDTH.
- LEN, 8, products per result; must be >= 1.
- SIGNED, 0, 0 = zero-extend products and detect unsigned carry-out; 1 = sign-extend products and detect two's-complement overflow.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- clr  in  1  synchronous abort/clear; same effect as reset; lower priority than rst_n.
- in_valid  in  1  in_prod valid.
- in_ready  out  1  block can accept in_prod.
- in_prod  in  WIDTH  product from the multiplier.
- out_valid  out  1  out_sum/out_ovf valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  ACC_WIDTH  sum of LEN products, modulo 2^ACC_WIDTH.
- out_ovf  out  1  overflow occurred in any addition of this result.

Behaviour:
- Reset / clr (sampled at rising edge, rst_n low or clr high):
  - state=ACC, acc=0, cnt=0, ovf_st=0.
  - out_valid=0, out_sum=0, out_ovf=0.
  - in_ready=1 on the following cycle.
  - Any partial sum or pending result is discarded.
- States: ACC, DONE. in_ready = (state==ACC), decoded combinationally from state only; it never depends on in_valid or out_ready.
- ACC, on accept (in_valid & in_ready):
  - ext = in_prod zero-extended (SIGNED=0) or sign-extended (SIGNED=1) to ACC_WIDTH.
  - nsum = acc + ext, modulo 2^ACC_WIDTH.
  - ov = carry-out (SIGNED=0), or operands of equal sign with result of different sign (SIGNED=1).
  - If cnt != LEN-1: acc<=nsum; cnt<=cnt+1; ovf_st<=ovf_st|ov.
  - If cnt == LEN-1: out_sum<=nsum; out_ovf<=ovf_st|ov; out_valid<=1; acc<=0; cnt<=0; ovf_st<=0; state<=DONE.
- ACC, no accept: all state holds; bubbles are not counted.
- DONE:
  - in_ready=0; in_valid and in_prod are ignored.
  - out_valid, out_sum and out_ovf are stable until out_ready is sampled high.
  - On out_ready: out_valid<=0, state<=ACC. out_sum/out_ovf keep their last values.
- Latency: out_valid rises in the cycle after the LEN-th accept.
- Minimum period per result: LEN accept cycles plus 1 DONE cycle.
- LEN=1: every accept moves to DONE; out_sum = ext(in_prod).
- out_ready while out_valid=0 has no effect.
- cnt width = max(1, clog2(LEN)).
- All outputs are registered except in_ready.
- No X propagation from in_prod while in_valid=0.

Test Plan:
- Unsigned full scale: defaults, 8 beats of in_prod=4'hF, out_ready=1 → out_valid high one cycle after the 8th accept, out_sum=12'h078, out_ovf=0, then in_ready=1 the next cycle.
- Backpressure and bubbles: beats 1..8 with in_valid low every other cycle; out_ready=0 for 5 cycles after out_valid → out_sum=36 held stable, in_ready=0 throughout, in_valid pulses in DONE ignored; out_ready=1 → out_valid drops next cycle.
- Signed: SIGNED=1, 8 beats of 4'hF (-1) → out_sum=12'hFF8, out_ovf=0; 8 beats of 4'h7 → out_sum=56, out_ovf=0.
- Overflow: SIGNED=0, ACC_WIDTH=6, 8 beats of 4'hF → out_sum=6'd56 (120 mod 64), out_ovf=1; next result from 8 beats of 0 → out_sum=0, out_ovf=0 (sticky cleared per result). SIGNED=1, ACC_WIDTH=6, 8 beats of 4'h7 → out_ovf=1.
- Reset mid-operation: 3 accepts of 4'h1, then rst_n=0 for 1 cycle → out_valid=0, out_sum=0; then 8 beats of 4'h1 → out_sum=8 (not 11). Repeat with clr=1 for 1 cycle → same result. Assert rst_n=0 while in DONE → out_valid=0 next cycle.
- clr priority: clr=1 on the same edge as the 8th accept → no result produced, state=ACC, cnt=0; the following 8 beats of 4'h2 → out_sum=16.

Source files
------------

// File: rtl/mac_accum_int4.sv
// Accumulates LEN consecutive multiplier products into one ACC_WIDTH-bit dot-product
// result with a sticky overflow flag, over valid/ready handshakes on both sides.
module mac_accum_int4 #(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 12,
  parameter int LEN       = 8,
  parameter int SIGNED    = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_prod,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic                 out_ovf
);

  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  typedef enum logic {ST_ACC, ST_DONE} state_t;

  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ovf_st_q, ovf_st_d;
  logic                   vld_q, vld_d;
  logic [ACC_WIDTH-1:0]   sum_q, sum_d;
  logic                   ovf_q, ovf_d;
  logic [ACC_WIDTH:0]     add_res;

  function automatic logic [ACC_WIDTH-1:0] extend(input logic [WIDTH-1:0] p);
    logic [ACC_WIDTH-1:0] r;
    if (SIGNED != 0) r = ACC_WIDTH'($signed(p));
    else             r = ACC_WIDTH'(p);
    return r;
  endfunction

  // Returns {overflow, sum}; overflow is carry-out or two's-complement overflow.
  function automatic logic [ACC_WIDTH:0] add_chk(input logic [ACC_WIDTH-1:0] a,
                                                 input logic [ACC_WIDTH-1:0] b);
    logic [ACC_WIDTH:0] wide;
    logic               ov;
    wide = {1'b0, a} + {1'b0, b};
    if (SIGNED != 0)
      ov = (a[ACC_WIDTH-1] == b[ACC_WIDTH-1]) && (wide[ACC_WIDTH-1] != a[ACC_WIDTH-1]);
    else
      ov = wide[ACC_WIDTH];
    return {ov, wide[ACC_WIDTH-1:0]};
  endfunction

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    ovf_st_d = ovf_st_q;
    vld_d    = vld_q;
    sum_d    = sum_q;
    ovf_d    = ovf_q;
    add_res  = add_chk(acc_q, extend(in_prod));
    if (clr) begin
      state_d  = ST_ACC;
      acc_d    = '0;
      cnt_d    = '0;
      ovf_st_d = 1'b0;
      vld_d    = 1'b0;
      sum_d    = '0;
      ovf_d    = 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (in_valid) begin
            if (cnt_q == LAST) begin
              sum_d    = add_res[ACC_WIDTH-1:0];
              ovf_d    = ovf_st_q | add_res[ACC_WIDTH];
              vld_d    = 1'b1;
              acc_d    = '0;
              cnt_d    = '0;
              ovf_st_d = 1'b0;
              state_d  = ST_DONE;
            end else begin
              acc_d    = add_res[ACC_WIDTH-1:0];
              cnt_d    = cnt_q + CNT_W'(1);
              ovf_st_d = ovf_st_q | add_res[ACC_WIDTH];
            end
          end
        end
        ST_DONE: begin
          // Result is held until the consumer takes it; inputs are ignored here.
          if (out_ready) begin
            vld_d   = 1'b0;
            state_d = ST_ACC;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_ACC;
      acc_q    <= '0;
      cnt_q    <= '0;
      ovf_st_q <= 1'b0;
      vld_q    <= 1'b0;
      sum_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      ovf_st_q <= ovf_st_d;
      vld_q    <= vld_d;
      sum_q    <= sum_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = vld_q;
  assign out_sum   = sum_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_mac_accum_int4.sv
// Scoreboard bench for mac_accum_int4: five lanes with different widths, signedness
// and lengths, each with its own driver, reference model and output monitor.
module tb_mac_accum_int4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic int aw_of(input int g);
    case (g)
      2, 3:    return 6;
      default: return 12;
    endcase
  endfunction

  function automatic int sg_of(input int g);
    return (g == 1 || g == 3) ? 1 : 0;
  endfunction

  function automatic int ln_of(input int g);
    return (g == 4) ? 1 : 8;
  endfunction

  function automatic void chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  for (genvar g = 0; g < 5; g++) begin : lane
    localparam int AW = aw_of(g);
    localparam int SG = sg_of(g);
    localparam int LN = ln_of(g);

    logic          rst_n, clr, in_valid, in_ready, out_valid, out_ready, out_ovf;
    logic [3:0]    in_prod;
    logic [AW-1:0] out_sum;

    logic [AW:0]   exp_q[$];
    bit            fin_pend = 0;
    bit            done = 0;
    bit            rnd_ordy = 0;
    int            beats = 0;
    longint        run = 0;
    bit            run_ov = 0;

    mac_accum_int4 #(.WIDTH(4), .ACC_WIDTH(AW), .LEN(LN), .SIGNED(SG)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_ovf(out_ovf)
    );

    // Reference: true arithmetic on integers, wrapped back into the result range.
    function automatic longint ext_val(input logic [3:0] p);
      if (SG != 0) return longint'($signed(p));
      return longint'(p);
    endfunction

    task automatic model_clear();
      beats = 0;
      run = 0;
      run_ov = 0;
    endtask

    task automatic model_accept(input logic [3:0] p);
      longint m, t;
      logic [AW-1:0] s;
      m = longint'(1) << AW;
      t = run + ext_val(p);
      if (SG == 0) begin
        if (t >= m) begin run_ov = 1; t = t - m; end
      end else begin
        if (t >= m / 2)  begin run_ov = 1; t = t - m; end
        if (t < -(m / 2)) begin run_ov = 1; t = t + m; end
      end
      run = t;
      beats++;
      if (beats == LN) begin
        s = run[AW-1:0];
        exp_q.push_back({run_ov, s});
        fin_pend = 1;
        model_clear();
      end
    endtask

    task automatic step();
      @(negedge clk);
      if (rnd_ordy) out_ready = 1'($urandom);
    endtask

    task automatic idle(input int n);
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
        in_prod = 4'($urandom);
        step();
      end
    endtask

    task automatic send(input logic [3:0] p, input bit with_clr);
      int n;
      n = 0;
      while (!in_ready && n < 300) begin
        in_valid = 1'($urandom);
        in_prod = 4'($urandom);
        step();
        n++;
      end
      if (!in_ready) begin
        checks++;
        errors++;
        $display("FAIL lane%0d in_ready_timeout: in_ready %0d expected 1", g, in_ready);
      end
      in_valid = 1'b1;
      in_prod = p;
      clr = with_clr;
      @(posedge clk);
      if (with_clr) model_clear();
      else          model_accept(p);
      step();
      in_valid = 1'b0;
      clr = 1'b0;
      in_prod = 4'($urandom);
    endtask

    task automatic rst_pulse(input bit use_clr);
      if (use_clr) clr = 1'b1;
      else         rst_n = 1'b0;
      step();
      clr = 1'b0;
      rst_n = 1'b1;
      model_clear();
    endtask

    task automatic burst(input logic [3:0] p, input int n);
      for (int i = 0; i < n; i++) send(p, 1'b0);
    endtask

    // Driver
    initial begin
      rst_n = 1'b0;
      clr = 1'b0;
      in_valid = 1'b0;
      in_prod = 4'h0;
      out_ready = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      out_ready = 1'b1;
      case (g)
        0: begin
          burst(4'hF, 8);
          idle(2);
          out_ready = 1'b0;
          for (int i = 1; i <= 8; i++) begin
            send(4'(i), 1'b0);
            idle(1);
          end
          for (int i = 0; i < 5; i++) begin
            in_valid = 1'($urandom);
            in_prod = 4'($urandom);
            step();
          end
          out_ready = 1'b1;
          idle(3);
          burst(4'h1, 3);
          rst_pulse(1'b0);
          burst(4'h1, 8);
          idle(2);
          burst(4'h1, 3);
          rst_pulse(1'b1);
          burst(4'h1, 8);
          idle(2);
          out_ready = 1'b0;
          burst(4'h1, 8);
          idle(2);
          rst_pulse(1'b0);
          out_ready = 1'b1;
          idle(1);
          burst(4'h3, 7);
          send(4'h3, 1'b1);
          burst(4'h2, 8);
          idle(2);
        end
        1: begin
          burst(4'hF, 8);
          idle(1);
          burst(4'h7, 8);
          idle(2);
        end
        2: begin
          burst(4'hF, 8);
          idle(1);
          burst(4'h0, 8);
          idle(2);
        end
        3: begin
          burst(4'h7, 8);
          idle(2);
        end
        default: idle(2);
      endcase
      rnd_ordy = 1;
      for (int r = 0; r < 30 * LN; r++) begin
        send(4'($urandom), ($urandom_range(0, 39) == 0));
        idle($urandom_range(0, 2));
      end
      rnd_ordy = 0;
      out_ready = 1'b1;
      for (int c = 0; c < 100 && (exp_q.size() != 0 || out_valid); c++) idle(1);
      if (exp_q.size() != 0) begin
        checks++;
        errors++;
        $display("FAIL lane%0d drain: %0d results outstanding, expected 0", g, exp_q.size());
      end
      done = 1;
    end

    // Monitor: samples just after each rising edge, when inputs are still those of the edge.
    logic          prev_vld = 1'b0;
    logic [AW-1:0] prev_sum = '0;
    logic          prev_ovf = 1'b0;
    bit            started = 0;
    logic [AW:0]   e;

    always @(posedge clk) begin
      #1;
      if (!rst_n || clr) begin
        started = 1;
        fin_pend = 0;
        chk($sformatf("lane%0d reset out_valid", g), out_valid, 0);
        chk($sformatf("lane%0d reset out_sum", g), out_sum, 0);
        chk($sformatf("lane%0d reset out_ovf", g), out_ovf, 0);
      end else if (started) begin
        if (prev_vld) begin
          chk($sformatf("lane%0d out_valid after ready=%0d", g, out_ready), out_valid, !out_ready);
          chk($sformatf("lane%0d held out_sum", g), out_sum, prev_sum);
          chk($sformatf("lane%0d held out_ovf", g), out_ovf, prev_ovf);
        end else begin
          chk($sformatf("lane%0d out_valid timing", g), out_valid, fin_pend);
          if (out_valid) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL lane%0d result: got sum %0d with no expected result", g, out_sum);
            end else begin
              e = exp_q.pop_front();
              chk($sformatf("lane%0d out_sum", g), out_sum, e[AW-1:0]);
              chk($sformatf("lane%0d out_ovf", g), out_ovf, e[AW]);
            end
          end
          fin_pend = 0;
        end
        chk($sformatf("lane%0d in_ready", g), in_ready, !out_valid);
      end
      prev_vld = out_valid;
      prev_sum = out_sum;
      prev_ovf = out_ovf;
    end
  end

  initial begin
    int c;
    c = 0;
    while (c < 60000 && !(lane[0].done && lane[1].done && lane[2].done &&
                          lane[3].done && lane[4].done)) begin
      @(negedge clk);
      c++;
    end
    if (c >= 60000) begin
      checks++;
      errors++;
      $display("FAIL timeout: lanes not done after %0d cycles", c);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
